fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage of the RISC-V pipeline, sitting directly upstream of `instruction_memory`. It owns the program counter, drives the byte address into the instruction memory, captures the combinationally-read instruction into the IF/ID pipeline register, and handles decode stalls, branch/jump redirects, EBREAK halt/resume and misaligned-target errors.

## Interface

Parameters:
- `ADDRESS_WIDTH`, default `PROGRAM_ADDRESS_WIDTH` (package `common`): PC and instruction address width in bits.
- `DATA_WIDTH`, default 32: instruction width in bits.
- `RESET_PC`, default 0: PC value loaded on reset. Must be 4-byte aligned.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_address`  out  ADDRESS_WIDTH  byte address to `instruction_memory`; equals the PC register (combinational).
- `imem_read_data`  in  DATA_WIDTH  instruction returned combinationally for `imem_address`.
- `stall`  in  1  decode cannot accept; hold the PC and IF/ID contents.
- `redirect_valid`  in  1  taken branch/jump from execute.
- `redirect_pc`  in  ADDRESS_WIDTH  redirect target byte address.
- `resume`  in  1  leave HALT and continue at the instruction after the EBREAK.
- `if_id_valid`  out  1  IF/ID holds a live instruction.
- `if_id_pc`  out  ADDRESS_WIDTH  address of `if_id_instr`.
- `if_id_pc_plus4`  out  ADDRESS_WIDTH  `if_id_pc + 4`, modulo 2^ADDRESS_WIDTH.
- `if_id_instr`  out  DATA_WIDTH  fetched instruction.
- `halted`  out  1  high in HALT or ERROR.
- `misaligned`  out  1  sticky; a redirect target had `redirect_pc[1:0] != 0`.
- `fetch_count`  out  32  count of instructions latched into IF/ID.

## Operation

- The state machine has three states: RUN, HALT and ERROR. Reset enters RUN.
- Reset values:
  - `pc = RESET_PC`, `if_id_valid = 0`, `if_id_pc = 0`, `if_id_pc_plus4 = 4`.
  - `if_id_instr = 32'h00000013` (NOP).
  - `halted = 0`, `misaligned = 0`, `fetch_count = 0`.
- Each edge is evaluated in priority order: `rst`, then `redirect_valid`, then `stall`, then normal fetch/`resume`.
- RUN, redirect with an aligned target:
  - `pc <= redirect_pc`, `if_id_valid <= 0`. This flushes the wrong-path instruction and overrides `stall`.
  - The instruction at the current PC is discarded, even if it is EBREAK.
- Redirect with a misaligned target (any state except ERROR):
  - `misaligned <= 1`, `if_id_valid <= 0`, PC unchanged, next state ERROR.
- RUN, `stall` high: PC, all `if_id_*` outputs and `fetch_count` hold.
- RUN, normal fetch:
  - IF/ID latches `{pc, pc+4, imem_read_data}` with `if_id_valid <= 1`.
  - `fetch_count <= fetch_count + 1`, wrapping at 2^32.
  - `pc <= pc + 4`, wrapping modulo 2^ADDRESS_WIDTH.
- RUN, fetched word is EBREAK (`32'h00100073`):
  - The EBREAK is latched as normal (valid, counted), the PC holds at the EBREAK address, next state HALT.
- HALT:
  - When `stall` is low, `if_id_valid <= 0`. Nothing is fetched and `fetch_count` holds.
  - An aligned redirect loads the PC, returns to RUN and clears `if_id_valid`. This covers an EBREAK that was on a wrong path.
  - `resume` without a redirect sets `pc <= pc + 4` and returns to RUN. The first post-halt fetch happens on the following edge.
  - Redirect and `resume` in the same cycle: the redirect wins.
- ERROR: only `rst` exits. `redirect_valid` and `resume` are ignored, `if_id_valid` is 0 and `misaligned` stays 1.
- `halted = (state != RUN)`, registered with the state.
- `fetch_count` increments only when IF/ID is loaded with `if_id_valid <= 1`.

## Timing

- `imem_address` is combinational from the PC register, with zero-cycle read. An instruction at PC p in cycle k appears on `if_id_*` after edge k.
- Sustained throughput is one instruction per cycle with no stall.
- Redirect asserted in cycle k:
  - PC equals the target after edge k, and `if_id_valid` is 0 during cycle k+1.
  - The target instruction is valid after edge k+1, giving a one-cycle bubble.
- A `stall` that deasserts in cycle k allows the fetch at edge k.
- Back-to-back redirects in consecutive cycles: each one reloads the PC, and `if_id_valid` stays 0 until the first cycle without a redirect.
- `rst` asserted mid-operation takes effect at the next edge regardless of `stall`, `redirect_valid` or state.

## Test plan

- Sequential fetch: RESET_PC=0, memory holds I0..I3 at 0,4,8,12, no stall.
  - IF/ID shows (0,I0),(4,I1),(8,I2),(12,I3) on four consecutive cycles.
  - `fetch_count` = 4.
- Stall: assert `stall` for 3 cycles while IF/ID holds (8,I2).
  - `if_id_*` and `imem_address` = 12 are frozen and `fetch_count` is unchanged.
  - After release, (12,I3) appears one edge later.
- Redirect with stall: `redirect_valid=1`, `redirect_pc=0x20`, `stall=1` in the same cycle.
  - Next cycle `if_id_valid=0` and `imem_address=0x20`.
  - The cycle after, IF/ID = (0x20, mem[8]).
- EBREAK: `32'h00100073` at 0x10.
  - It is latched valid, `halted=1`, and `if_id_valid` drops the next cycle.
  - Pulsing `resume` gives `imem_address=0x14`, with (0x14, mem[5]) latched one edge later.
  - A redirect to 0x40 during HALT instead resumes at 0x40.
- Misaligned: `redirect_pc=0x22`.
  - `misaligned=1`, `halted=1`, and the PC stays at its prior value.
  - A later aligned redirect and `resume` are ignored.
  - `rst` restores PC=RESET_PC with all flags 0.
- Wrap: ADDRESS_WIDTH=6, redirect to 0x3C.
  - The next PC is 0x00 and `if_id_pc_plus4` for 0x3C equals 0x00.

Source files
------------

// File: rtl/common.sv
// Shared pipeline-wide constants.
// PROGRAM_ADDRESS_WIDTH sets the default width of every instruction address.
package common;
  localparam int PROGRAM_ADDRESS_WIDTH = 32;
endpackage

// File: rtl/fetch_stage_if.sv
// Fetch stage bundle: instruction memory port, execute/decode controls and the IF/ID register outputs.
// The master modport is the fetch stage itself; the slave modport is its surroundings.
interface fetch_stage_if #(
  parameter int ADDRESS_WIDTH = common::PROGRAM_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = 32
);
  logic [ADDRESS_WIDTH-1:0] imem_address;
  logic [DATA_WIDTH-1:0]    imem_read_data;
  logic                     stall;
  logic                     redirect_valid;
  logic [ADDRESS_WIDTH-1:0] redirect_pc;
  logic                     resume;
  logic                     if_id_valid;
  logic [ADDRESS_WIDTH-1:0] if_id_pc;
  logic [ADDRESS_WIDTH-1:0] if_id_pc_plus4;
  logic [DATA_WIDTH-1:0]    if_id_instr;
  logic                     halted;
  logic                     misaligned;
  logic [31:0]              fetch_count;

  modport master (
    output imem_address,
    input  imem_read_data,
    input  stall,
    input  redirect_valid,
    input  redirect_pc,
    input  resume,
    output if_id_valid,
    output if_id_pc,
    output if_id_pc_plus4,
    output if_id_instr,
    output halted,
    output misaligned,
    output fetch_count
  );

  modport slave (
    input  imem_address,
    output imem_read_data,
    output stall,
    output redirect_valid,
    output redirect_pc,
    output resume,
    input  if_id_valid,
    input  if_id_pc,
    input  if_id_pc_plus4,
    input  if_id_instr,
    input  halted,
    input  misaligned,
    input  fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC owner, one-cycle IF/ID register, redirect/EBREAK-halt/misaligned-error FSM.
// Latency: zero-cycle imem read, fetched word visible one edge later; stall freezes PC and IF/ID.
module fetch_stage #(
  parameter int                       ADDRESS_WIDTH = common::PROGRAM_ADDRESS_WIDTH,
  parameter int                       DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  localparam logic [DATA_WIDTH-1:0]    NOP    = DATA_WIDTH'(32'h0000_0013);
  localparam logic [DATA_WIDTH-1:0]    EBREAK = DATA_WIDTH'(32'h0010_0073);
  localparam logic [ADDRESS_WIDTH-1:0] FOUR   = ADDRESS_WIDTH'(4);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic [ADDRESS_WIDTH-1:0] if_pc_q, if_pc_d;
  logic [ADDRESS_WIDTH-1:0] if_pc4_q, if_pc4_d;
  logic [DATA_WIDTH-1:0]    if_instr_q, if_instr_d;
  logic                     if_valid_q, if_valid_d;
  logic                     halted_q, halted_d;
  logic                     misaligned_q, misaligned_d;
  logic [31:0]              fetch_count_q, fetch_count_d;

  logic [ADDRESS_WIDTH-1:0] pc_plus4;
  logic                     target_aligned;

  assign pc_plus4       = pc_q + FOUR;
  assign target_aligned = (bus.redirect_pc[1:0] == 2'b00);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_pc_d       = if_pc_q;
    if_pc4_d      = if_pc4_q;
    if_instr_d    = if_instr_q;
    if_valid_d    = if_valid_q;
    misaligned_d  = misaligned_q;
    fetch_count_d = fetch_count_q;

    case (state_q)
      ST_RUN, ST_HALT: begin
        if (bus.redirect_valid) begin
          // Redirect flushes IF/ID and beats both stall and resume.
          if_valid_d = 1'b0;
          if (target_aligned) begin
            pc_d    = bus.redirect_pc;
            state_d = ST_RUN;
          end else begin
            misaligned_d = 1'b1;
            state_d      = ST_ERROR;
          end
        end else if (bus.stall) begin
          if_valid_d = if_valid_q;
        end else if (state_q == ST_RUN) begin
          if_pc_d       = pc_q;
          if_pc4_d      = pc_plus4;
          if_instr_d    = bus.imem_read_data;
          if_valid_d    = 1'b1;
          fetch_count_d = fetch_count_q + 32'd1;
          // EBREAK parks the PC on itself so resume can step past it.
          if (bus.imem_read_data == EBREAK) begin
            state_d = ST_HALT;
          end else begin
            pc_d = pc_plus4;
          end
        end else begin
          if_valid_d = 1'b0;
          if (bus.resume) begin
            pc_d    = pc_plus4;
            state_d = ST_RUN;
          end
        end
      end
      default: begin
        if_valid_d = 1'b0;
      end
    endcase

    halted_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      if_pc_q       <= '0;
      if_pc4_q      <= FOUR;
      if_instr_q    <= NOP;
      if_valid_q    <= 1'b0;
      halted_q      <= 1'b0;
      misaligned_q  <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_pc_q       <= if_pc_d;
      if_pc4_q      <= if_pc4_d;
      if_instr_q    <= if_instr_d;
      if_valid_q    <= if_valid_d;
      halted_q      <= halted_d;
      misaligned_q  <= misaligned_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign bus.imem_address   = pc_q;
  assign bus.if_id_valid    = if_valid_q;
  assign bus.if_id_pc       = if_pc_q;
  assign bus.if_id_pc_plus4 = if_pc4_q;
  assign bus.if_id_instr    = if_instr_q;
  assign bus.halted         = halted_q;
  assign bus.misaligned     = misaligned_q;
  assign bus.fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: stimulus pushes expected IF/ID loads into a scoreboard,
// a negedge monitor pops them whenever fetch_count advances with a valid instruction.
module tb_fetch_stage;

  localparam logic [31:0] EBRK = 32'h0010_0073;

  typedef struct packed {
    logic [7:0]  pc;
    logic [7:0]  pc4;
    logic [31:0] instr;
    logic [31:0] cnt;
  } exp_t;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  exp_t sb_q[$];
  logic [31:0] mem [0:63];

  fetch_stage_if #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32)) bus ();
  fetch_stage_if #(.ADDRESS_WIDTH(6), .DATA_WIDTH(32)) bus_w ();

  fetch_stage #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32), .RESET_PC(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  fetch_stage #(.ADDRESS_WIDTH(6), .DATA_WIDTH(32), .RESET_PC(6'h00)) dut_w (
    .clk (clk),
    .rst (rst),
    .bus (bus_w)
  );

  assign bus.imem_read_data   = mem[bus.imem_address[7:2]];
  assign bus_w.imem_read_data = 32'hB000_0000 | {26'd0, bus_w.imem_address};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] pc, input logic [31:0] instr, input logic [31:0] cnt);
    exp_t e;
    e.pc    = pc;
    e.pc4   = pc + 8'd4;
    e.instr = instr;
    e.cnt   = cnt;
    sb_q.push_back(e);
  endtask

  task automatic expect_state(input string tag, input logic [7:0] addr, input logic v,
                              input logic h, input logic m, input logic [31:0] cnt);
    chk({tag, ".imem_address"}, 32'(bus.imem_address), 32'(addr));
    chk({tag, ".if_id_valid"}, 32'(bus.if_id_valid), 32'(v));
    chk({tag, ".halted"}, 32'(bus.halted), 32'(h));
    chk({tag, ".misaligned"}, 32'(bus.misaligned), 32'(m));
    chk({tag, ".fetch_count"}, bus.fetch_count, cnt);
  endtask

  // Monitor: a new IF/ID load is signalled by fetch_count advancing while valid.
  initial begin
    logic [31:0] last_cnt;
    exp_t e;
    last_cnt = 32'd0;
    forever begin
      @(negedge clk);
      if (!rst && bus.if_id_valid && bus.fetch_count != last_cnt) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_fetch: got pc %h count %0d expected no load", bus.if_id_pc, bus.fetch_count);
        end else begin
          e = sb_q.pop_front();
          chk("sb.if_id_pc", 32'(bus.if_id_pc), 32'(e.pc));
          chk("sb.if_id_pc_plus4", 32'(bus.if_id_pc_plus4), 32'(e.pc4));
          chk("sb.if_id_instr", bus.if_id_instr, e.instr);
          chk("sb.fetch_count", bus.fetch_count, e.cnt);
        end
      end
      last_cnt = bus.fetch_count;
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | 32'(i);
    mem[4] = EBRK;
    rst = 1'b1;
    bus.stall = 1'b0;   bus.redirect_valid = 1'b0;   bus.redirect_pc = 8'h00;   bus.resume = 1'b0;
    bus_w.stall = 1'b0; bus_w.redirect_valid = 1'b0; bus_w.redirect_pc = 6'h00; bus_w.resume = 1'b0;

    // Reset values
    step(); step();
    expect_state("reset", 8'h00, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("reset.if_id_pc", 32'(bus.if_id_pc), 32'h0);
    chk("reset.if_id_pc_plus4", 32'(bus.if_id_pc_plus4), 32'h4);
    chk("reset.if_id_instr", bus.if_id_instr, 32'h0000_0013);
    rst = 1'b0;

    // Sequential fetch of I0..I2
    push(8'h00, 32'hA000_0000, 32'd1); step();
    push(8'h04, 32'hA000_0001, 32'd2); step();
    push(8'h08, 32'hA000_0002, 32'd3); step();
    expect_state("seq", 8'h0C, 1'b1, 1'b0, 1'b0, 32'd3);

    // Stall three cycles holding (8,I2)
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_state("stall", 8'h0C, 1'b1, 1'b0, 1'b0, 32'd3);
      chk("stall.if_id_pc", 32'(bus.if_id_pc), 32'h08);
      chk("stall.if_id_instr", bus.if_id_instr, 32'hA000_0002);
    end
    bus.stall = 1'b0;
    push(8'h0C, 32'hA000_0003, 32'd4); step();
    expect_state("unstall", 8'h10, 1'b1, 1'b0, 1'b0, 32'd4);

    // Redirect overrides stall; EBREAK at 0x10 on the wrong path is discarded
    bus.redirect_valid = 1'b1; bus.redirect_pc = 8'h20; bus.stall = 1'b1;
    step();
    bus.redirect_valid = 1'b0; bus.stall = 1'b0;
    expect_state("redir_stall", 8'h20, 1'b0, 1'b0, 1'b0, 32'd4);
    push(8'h20, 32'hA000_0008, 32'd5); step();
    expect_state("redir_tgt", 8'h24, 1'b1, 1'b0, 1'b0, 32'd5);

    // EBREAK then resume
    bus.redirect_valid = 1'b1; bus.redirect_pc = 8'h10;
    step();
    bus.redirect_valid = 1'b0;
    push(8'h10, EBRK, 32'd6); step();
    expect_state("ebreak", 8'h10, 1'b1, 1'b1, 1'b0, 32'd6);
    step();
    expect_state("halt", 8'h10, 1'b0, 1'b1, 1'b0, 32'd6);
    step();
    expect_state("halt2", 8'h10, 1'b0, 1'b1, 1'b0, 32'd6);
    bus.resume = 1'b1;
    step();
    bus.resume = 1'b0;
    expect_state("resume", 8'h14, 1'b0, 1'b0, 1'b0, 32'd6);
    push(8'h14, 32'hA000_0005, 32'd7); step();

    // EBREAK again, left via redirect to 0x40 that also beats resume
    bus.redirect_valid = 1'b1; bus.redirect_pc = 8'h10;
    step();
    bus.redirect_valid = 1'b0;
    push(8'h10, EBRK, 32'd8); step();
    step();
    expect_state("halt3", 8'h10, 1'b0, 1'b1, 1'b0, 32'd8);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 8'h40; bus.resume = 1'b1;
    step();
    bus.redirect_valid = 1'b0; bus.resume = 1'b0;
    expect_state("halt_redir", 8'h40, 1'b0, 1'b0, 1'b0, 32'd8);
    push(8'h40, 32'hA000_0010, 32'd9); step();

    // Misaligned redirect locks into ERROR
    bus.redirect_valid = 1'b1; bus.redirect_pc = 8'h22;
    step();
    bus.redirect_valid = 1'b0;
    expect_state("misalign", 8'h44, 1'b0, 1'b1, 1'b1, 32'd9);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 8'h30; bus.resume = 1'b1;
    step();
    bus.redirect_valid = 1'b0; bus.resume = 1'b0;
    expect_state("error_ign", 8'h44, 1'b0, 1'b1, 1'b1, 32'd9);
    step();
    expect_state("error_hold", 8'h44, 1'b0, 1'b1, 1'b1, 32'd9);

    // Reset clears ERROR
    rst = 1'b1;
    step();
    rst = 1'b0;
    expect_state("rereset", 8'h00, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("rereset.if_id_instr", bus.if_id_instr, 32'h0000_0013);

    // Back-to-back redirects
    bus.redirect_valid = 1'b1; bus.redirect_pc = 8'h20;
    step();
    expect_state("b2b_1", 8'h20, 1'b0, 1'b0, 1'b0, 32'd0);
    bus.redirect_pc = 8'h28;
    step();
    bus.redirect_valid = 1'b0;
    expect_state("b2b_2", 8'h28, 1'b0, 1'b0, 1'b0, 32'd0);
    push(8'h28, 32'hA000_000A, 32'd1); step();
    push(8'h2C, 32'hA000_000B, 32'd2); step();
    bus.stall = 1'b1;

    // Address wrap on the 6-bit instance
    bus_w.redirect_valid = 1'b1; bus_w.redirect_pc = 6'h3C;
    step();
    bus_w.redirect_valid = 1'b0;
    chk("wrap.redir_addr", 32'(bus_w.imem_address), 32'h3C);
    chk("wrap.bubble", 32'(bus_w.if_id_valid), 32'h0);
    step();
    chk("wrap.next_pc", 32'(bus_w.imem_address), 32'h00);
    chk("wrap.if_id_pc", 32'(bus_w.if_id_pc), 32'h3C);
    chk("wrap.if_id_pc_plus4", 32'(bus_w.if_id_pc_plus4), 32'h00);
    chk("wrap.if_id_instr", bus_w.if_id_instr, 32'hB000_003C);
    chk("wrap.valid", 32'(bus_w.if_id_valid), 32'h1);

    step(); step();
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
